muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and result bundle between the pipeline and the multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface muldiv_if #(parameter int W = 32);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] mt_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, opA, opB, mthi, mtlo, mt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, opA, opB, mthi, mtlo, mt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO unit: W-cycle shift-add multiply and restoring divide
// on operand magnitudes, followed by one sign-fix cycle.
module muldiv_unit #(
    parameter int W = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int            CW   = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t       r_state;
    state_t       w_state_next;
    logic         r_is_div;
    logic         r_sign_a;
    logic         r_sign_b;
    logic         r_div0;
    logic [CW-1:0] r_cnt;
    logic [W-1:0] r_m;
    logic [W-1:0] r_upper;
    logic [W-1:0] r_lower;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic         r_done;

    logic         w_signed;
    logic         w_sa;
    logic         w_sb;
    logic [W-1:0] w_abs_a;
    logic [W-1:0] w_abs_b;
    logic [W:0]   w_addend;
    logic [W:0]   w_sum;
    logic [W:0]   w_shift;
    logic [W:0]   w_diff;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0] w_quo;
    logic [W-1:0] w_rem;

    assign w_signed = ~bus.op[0];
    assign w_sa     = w_signed & bus.opA[W-1];
    assign w_sb     = w_signed & bus.opB[W-1];
    assign w_abs_a  = w_sa ? -bus.opA : bus.opA;
    assign w_abs_b  = w_sb ? -bus.opB : bus.opB;

    // Multiply: r_upper accumulates, r_lower holds the multiplier and collects low product bits.
    assign w_addend = r_lower[0] ? {1'b0, r_m} : {(W+1){1'b0}};
    assign w_sum    = {1'b0, r_upper} + w_addend;
    // Divide: r_upper is the partial remainder, r_lower shifts dividend out and quotient in.
    assign w_shift  = {r_upper, r_lower[W-1]};
    assign w_diff   = w_shift - {1'b0, r_m};

    assign w_prod     = {r_upper, r_lower};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    // A zero divisor leaves an all-ones quotient that must not be sign-flipped.
    assign w_quo      = r_div0 ? {W{1'b1}} : ((r_sign_a ^ r_sign_b) ? -r_lower : r_lower);
    assign w_rem      = r_sign_a ? -r_upper : r_upper;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = CALC;
            CALC:    if (r_cnt == LAST) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
            r_m      <= '0;
            r_upper  <= '0;
            r_lower  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_is_div <= bus.op[1];
                        r_sign_a <= w_sa;
                        r_sign_b <= w_sb;
                        r_div0   <= bus.op[1] && (bus.opB == '0);
                        r_cnt    <= '0;
                        r_upper  <= '0;
                        r_m      <= bus.op[1] ? w_abs_b : w_abs_a;
                        r_lower  <= bus.op[1] ? w_abs_a : w_abs_b;
                    end else begin
                        if (bus.mthi) r_hi <= bus.mt_data;
                        if (bus.mtlo) r_lo <= bus.mt_data;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        if (!w_diff[W]) begin
                            r_upper <= w_diff[W-1:0];
                            r_lower <= {r_lower[W-2:0], 1'b1};
                        end else begin
                            r_upper <= w_shift[W-1:0];
                            r_lower <= {r_lower[W-2:0], 1'b0};
                        end
                    end else begin
                        r_upper <= w_sum[W:1];
                        r_lower <= {w_sum[0], r_lower[W-1:1]};
                    end
                end
                FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end else begin
                        r_lo <= w_prod_fix[W-1:0];
                        r_hi <= w_prod_fix[2*W-1:W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed/unsigned results, divide corner
// cases, reset abort, and moves/starts while busy.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_if #(.W(32)) bus ();

    muldiv_unit #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issue one operation and watch a fixed 40-cycle window starting at the start edge.
    // k counts edges since the start edge; samples are taken 1 time unit after each edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int dist_k, input logic mt_with_start,
                          output logic [31:0] r_hi, output logic [31:0] r_lo,
                          output int busy_cnt, output int done_cnt, output int done_k,
                          output logic held, output logic busy_end);
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        pre_hi = bus.hi;
        pre_lo = bus.lo;
        busy_cnt = 0; done_cnt = 0; done_k = -1; held = 1'b1;
        r_hi = bus.hi; r_lo = bus.lo;
        bus.op = op; bus.opA = a; bus.opB = b; bus.start = 1'b1;
        bus.mthi = mt_with_start; bus.mtlo = mt_with_start; bus.mt_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++; done_k = k; r_hi = bus.hi; r_lo = bus.lo;
            end
            if (k <= 32 && (bus.hi !== pre_hi || bus.lo !== pre_lo)) held = 1'b0;
            if (k == 0) begin
                bus.opA = ~a; bus.opB = ~b; bus.op = ~op;
            end
            if (k == dist_k) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
                bus.mt_data = 32'hBAD0_BAD0; bus.op = 2'b11; bus.opA = 32'd1; bus.opB = 32'd1;
            end else begin
                bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            end
            @(posedge clk); #1;
        end
        busy_end = bus.busy;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d done_pulses=%0d done_at=%0d",
                 op, a, b, r_hi, r_lo, busy_cnt, done_cnt, done_k);
    endtask

    task automatic test_reset();
        bus.start = 0; bus.op = 0; bus.opA = 0; bus.opB = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.mt_data = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    endtask

    task automatic test_mult();
        logic [31:0] h, l; int bc, dc, dk; logic hd, be;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL multu_done_pulses got %0d want 1", dc); end
        n_cmp++; if (dk != 33) begin n_bad++; $display("FAIL multu_done_cycle got %0d want 33", dk); end
        n_cmp++; if (h !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi got %h want fffffffe", h); end
        n_cmp++; if (l !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo got %h want 00000001", l); end
        n_cmp++; if (hd !== 1'b1) begin n_bad++; $display("FAIL multu_hilo_held got %b want 1", hd); end
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (h !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi got %h want ffffffff", h); end
        n_cmp++; if (l !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_neg_lo got %h want fffffff1", l); end
        n_cmp++; if (hd !== 1'b1) begin n_bad++; $display("FAIL mult_neg_hilo_held got %b want 1", hd); end
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (h !== 32'h4000_0000) begin n_bad++; $display("FAIL mult_min_hi got %h want 40000000", h); end
        n_cmp++; if (l !== 32'h0) begin n_bad++; $display("FAIL mult_min_lo got %h want 0", l); end
    endtask

    task automatic test_div();
        logic [31:0] h, l; int bc, dc, dk; logic hd, be;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (l !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_lo got %h want fffffffd", l); end
        n_cmp++; if (h !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_hi got %h want ffffffff", h); end
        run_op(2'b11, 32'd7, 32'd0, -1, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (l !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divu_zero_lo got %h want ffffffff", l); end
        n_cmp++; if (h !== 32'h7) begin n_bad++; $display("FAIL divu_zero_hi got %h want 00000007", h); end
        n_cmp++; if (dk != 33) begin n_bad++; $display("FAIL divu_zero_done_cycle got %0d want 33", dk); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, -1, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (l !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_zero_lo got %h want ffffffff", l); end
        n_cmp++; if (h !== 32'hFFFF_FFF9) begin n_bad++; $display("FAIL div_zero_hi got %h want fffffff9", h); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (l !== 32'h8000_0000) begin n_bad++; $display("FAIL div_min_lo got %h want 80000000", l); end
        n_cmp++; if (h !== 32'h0) begin n_bad++; $display("FAIL div_min_hi got %h want 0", h); end
        run_op(2'b11, 32'd100, 32'd7, -1, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (l !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h want 0000000e", l); end
        n_cmp++; if (h !== 32'd2) begin n_bad++; $display("FAIL divu_hi got %h want 00000002", h); end
        n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL divu_busy_cycles got %0d want 33", bc); end
    endtask

    task automatic test_abort();
        logic [31:0] h, l; int bc, dc, dk; logic hd, be; int dn;
        bus.op = 2'b01; bus.opA = 32'hFFFF_FFFF; bus.opB = 32'h1234_5678; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1; bus.start = 1'b1; bus.mthi = 1'b1; bus.mt_data = 32'h5555_5555;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0; bus.mthi = 1'b0;
        $display("abort: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL abort_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL abort_lo got %h want 0", bus.lo); end
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1) dn++;
            @(posedge clk); #1;
        end
        n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL abort_done_pulses got %0d want 0", dn); end
        run_op(2'b11, 32'd9, 32'd4, -1, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (l !== 32'd2) begin n_bad++; $display("FAIL after_abort_lo got %h want 00000002", l); end
        n_cmp++; if (h !== 32'd1) begin n_bad++; $display("FAIL after_abort_hi got %h want 00000001", h); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] h, l; int bc, dc, dk; logic hd, be;
        run_op(2'b01, 32'd6, 32'd7, 5, 1'b0, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (l !== 32'd42) begin n_bad++; $display("FAIL ignore_lo got %h want 0000002a", l); end
        n_cmp++; if (h !== 32'd0) begin n_bad++; $display("FAIL ignore_hi got %h want 0", h); end
        n_cmp++; if (hd !== 1'b1) begin n_bad++; $display("FAIL ignore_hilo_held got %b want 1", hd); end
        n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL ignore_done_pulses got %0d want 1", dc); end
        n_cmp++; if (be !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue got busy=%b want 0", be); end
    endtask

    task automatic test_moves();
        logic [31:0] h, l; int bc, dc, dk; logic hd, be;
        bus.mthi = 1'b1; bus.mt_data = 32'h0000_1234;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        $display("mthi: hi=%h lo=%h done=%b", bus.hi, bus.lo, bus.done);
        n_cmp++; if (bus.hi !== 32'h1234) begin n_bad++; $display("FAIL mthi_hi got %h want 00001234", bus.hi); end
        n_cmp++; if (bus.lo !== 32'd42) begin n_bad++; $display("FAIL mthi_lo got %h want 0000002a", bus.lo); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL mthi_done got %b want 0", bus.done); end
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'hABCD_0001;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        $display("mthi+mtlo: hi=%h lo=%h", bus.hi, bus.lo);
        n_cmp++; if (bus.hi !== 32'hABCD_0001) begin n_bad++; $display("FAIL mtboth_hi got %h want abcd0001", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hABCD_0001) begin n_bad++; $display("FAIL mtboth_lo got %h want abcd0001", bus.lo); end
        run_op(2'b11, 32'd100, 32'd7, -1, 1'b1, h, l, bc, dc, dk, hd, be);
        n_cmp++; if (l !== 32'd14) begin n_bad++; $display("FAIL start_prio_lo got %h want 0000000e", l); end
        n_cmp++; if (h !== 32'd2) begin n_bad++; $display("FAIL start_prio_hi got %h want 00000002", h); end
        n_cmp++; if (hd !== 1'b1) begin n_bad++; $display("FAIL start_prio_held got %b want 1", hd); end
        rst = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'h7777_7777;
        @(posedge clk); #1;
        rst = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        $display("rst+mt: hi=%h lo=%h", bus.hi, bus.lo);
        n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL rst_prio_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL rst_prio_lo got %h want 0", bus.lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_abort();
        test_busy_ignore();
        test_moves();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
